i2c_register_bank: RTL and testbench

- Parametrised successor of the I2C slave register interface. Maps the 8-bit I2C register address space onto four regions:
  - an OSD RAM write window with page select;
  - a bank of staged 8-bit config registers with atomic commit;
  - 32-bit status words read coherently through a snapshot latch;
  - self-timed command pulses.
- Sits between i2cSlave and the video/OSD/control logic.

---
 rtl/i2c_register_bank.sv | 261 ++++++++++++++++++++++++++
 tb/tb_i2c_register_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_register_bank.sv
// ---------------------------------------------------------------------------
// i2c_register_bank
//
// Register file behind an I2C slave.  The 8-bit register address space is
// split into the following regions:
//   8'h00-8'h7F : OSD RAM write window (page selected through 8'h80)
//   8'h80       : OSD page register
//   CFG_BASE..  : NUM_CFG staged config bytes, commit register after them
//   STAT_BASE.. : NUM_STAT big-endian 32-bit status words (snapshot on MSB)
//   PULSE_BASE..: NUM_PULSE self-timed command pulses
//
// Ports:
//   clk, reset        : system clock, synchronous active-high reset
//   addr, dataIn      : register address / write data from the I2C slave
//   writeEn, readEn   : level requests; the design acts on their rising edges
//   dataOut           : registered read data (one cycle after addr)
//   ram_dataIn        : OSD RAM write data
//   ram_wraddress     : OSD RAM write address {page, addr[6:0]}
//   ram_wren          : single-cycle OSD RAM write enable
//   cfg_out           : committed config bank, reg i at [8i+7:8i]
//   cfg_commit        : one-cycle strobe when cfg_out is updated
//   stat_in           : status words, word k at [32k+31:32k]
//   pulse_out         : command pulse outputs
// ---------------------------------------------------------------------------
module i2c_register_bank #(
    parameter int                  NUM_CFG       = 16,
    parameter logic [7:0]          CFG_BASE      = 8'h90,
    parameter logic [8*NUM_CFG-1:0] CFG_RESET    = {NUM_CFG{8'h00}},
    parameter int                  NUM_STAT      = 8,
    parameter logic [7:0]          STAT_BASE     = 8'hA0,
    parameter int                  NUM_PULSE     = 8,
    parameter logic [7:0]          PULSE_BASE    = 8'hF0,
    parameter int                  PULSE_LEN     = 4,
    parameter int                  RAM_PAGE_BITS = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 addr,
    input  logic [7:0]                 dataIn,
    input  logic                       writeEn,
    input  logic                       readEn,
    output logic [7:0]                 dataOut,
    output logic [7:0]                 ram_dataIn,
    output logic [RAM_PAGE_BITS+6:0]   ram_wraddress,
    output logic                       ram_wren,
    output logic [8*NUM_CFG-1:0]       cfg_out,
    output logic                       cfg_commit,
    input  logic [32*NUM_STAT-1:0]     stat_in,
    output logic [NUM_PULSE-1:0]       pulse_out
);

    // Index widths, kept at least one bit wide for single-entry regions.
    localparam int CIW = (NUM_CFG   > 1) ? $clog2(NUM_CFG)   : 1;
    localparam int SIW = (NUM_STAT  > 1) ? $clog2(NUM_STAT)  : 1;
    localparam int PIW = (NUM_PULSE > 1) ? $clog2(NUM_PULSE) : 1;

    // Region bounds in 9 bits so that end-of-region addresses never wrap.
    localparam logic [8:0] CFG_LO    = {1'b0, CFG_BASE};
    localparam logic [8:0] CFG_END   = CFG_LO + 9'(NUM_CFG);   // commit register
    localparam logic [8:0] STAT_LO   = {1'b0, STAT_BASE};
    localparam logic [8:0] STAT_END  = STAT_LO + 9'(4 * NUM_STAT);
    localparam logic [8:0] PULSE_LO  = {1'b0, PULSE_BASE};
    localparam logic [8:0] PULSE_END = PULSE_LO + 9'(NUM_PULSE);
    localparam logic [7:0] PLEN      = 8'(PULSE_LEN);

    // Inclusive integer bounds for the map legality check.
    localparam int C_LO = int'(CFG_BASE);
    localparam int C_HI = int'(CFG_BASE) + NUM_CFG;
    localparam int S_LO = int'(STAT_BASE);
    localparam int S_HI = int'(STAT_BASE) + 4 * NUM_STAT - 1;
    localparam int P_LO = int'(PULSE_BASE);
    localparam int P_HI = int'(PULSE_BASE) + NUM_PULSE - 1;

    localparam bit RANGES_OK = (NUM_CFG >= 1) && (NUM_CFG <= 32) &&
                               (NUM_STAT >= 1) && (NUM_STAT <= 16) &&
                               (NUM_PULSE >= 1) && (NUM_PULSE <= 16) &&
                               (PULSE_LEN >= 1) && (PULSE_LEN <= 255) &&
                               (RAM_PAGE_BITS >= 1) && (RAM_PAGE_BITS <= 8);
    localparam bit BOUNDS_OK = (C_LO >= 129) && (S_LO >= 129) && (P_LO >= 129) &&
                               (C_HI <= 255) && (S_HI <= 255) && (P_HI <= 255);
    localparam bit DISJOINT  = ((C_HI < S_LO) || (S_HI < C_LO)) &&
                               ((C_HI < P_LO) || (P_HI < C_LO)) &&
                               ((S_HI < P_LO) || (P_HI < S_LO));

    // Reject illegal maps at elaboration time.
    if (!(RANGES_OK && BOUNDS_OK && DISJOINT)) begin : g_map_error
        $error("i2c_register_bank: illegal parameters or overlapping register regions");
    end

    // Big-endian byte extraction from a status word (byte 0 is the MSB).
    function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // State
    logic                     we_d_r;
    logic                     rd_d_r;
    logic [RAM_PAGE_BITS-1:0] page_r;
    logic [7:0]               staging_r [NUM_CFG];
    logic [31:0]              snap_r;
    logic [SIW-1:0]           snap_idx_r;
    logic                     snap_valid_r;
    logic [7:0]               cnt_r     [NUM_PULSE];

    // Decode / next-state signals
    logic [8:0]     addr9_s;
    logic [8:0]     cfg_off_s;
    logic [8:0]     stat_off_s;
    logic [8:0]     pulse_off_s;
    logic           is_ram_s;
    logic           is_page_s;
    logic           is_cfg_s;
    logic           is_commit_s;
    logic           is_stat_s;
    logic           is_pulse_s;
    logic [CIW-1:0] cfg_idx_s;
    logic [SIW-1:0] stat_word_s;
    logic [1:0]     stat_byte_s;
    logic [PIW-1:0] pulse_idx_s;
    logic [31:0]    live_word_s;
    logic           wr_rise_s;
    logic           rd_rise_s;
    logic [7:0]     rd_data_s;
    logic [7:0]     cnt_next_s [NUM_PULSE];

    // Address decode shared by read and write paths.
    always_comb begin
        addr9_s     = {1'b0, addr};
        cfg_off_s   = addr9_s - CFG_LO;
        stat_off_s  = addr9_s - STAT_LO;
        pulse_off_s = addr9_s - PULSE_LO;
        is_ram_s    = ~addr[7];
        is_page_s   = (addr == 8'h80);
        is_cfg_s    = (addr9_s >= CFG_LO)   && (addr9_s < CFG_END);
        is_commit_s = (addr9_s == CFG_END);
        is_stat_s   = (addr9_s >= STAT_LO)  && (addr9_s < STAT_END);
        is_pulse_s  = (addr9_s >= PULSE_LO) && (addr9_s < PULSE_END);
        cfg_idx_s   = cfg_off_s[CIW-1:0];
        stat_word_s = stat_off_s[SIW+1:2];
        stat_byte_s = stat_off_s[1:0];
        pulse_idx_s = pulse_off_s[PIW-1:0];
        live_word_s = stat_in[{stat_word_s, 5'b00000} +: 32];
        wr_rise_s   = writeEn & ~we_d_r;
        rd_rise_s   = readEn & ~rd_d_r;
    end

    // Read data mux; dataOut registers this every cycle.
    always_comb begin
        rd_data_s = 8'h00;
        if (is_page_s) begin
            rd_data_s = 8'(page_r);
        end else if (is_cfg_s) begin
            rd_data_s = staging_r[cfg_idx_s];
        end else if (is_commit_s) begin
            rd_data_s = 8'h00;
        end else if (is_stat_s) begin
            // Lower bytes come from the snapshot of the same word so a
            // 4-byte burst returns one coherent 32-bit value.
            if ((stat_byte_s != 2'd0) && snap_valid_r && (snap_idx_r == stat_word_s)) begin
                rd_data_s = be_byte(snap_r, stat_byte_s);
            end else begin
                rd_data_s = be_byte(live_word_s, stat_byte_s);
            end
        end else if (is_pulse_s) begin
            rd_data_s = {7'b0000000, pulse_out[pulse_idx_s]};
        end else begin
            rd_data_s = 8'h00;
        end
    end

    // Pulse counters: a write loads or cancels, otherwise count down to zero.
    always_comb begin
        for (int j = 0; j < NUM_PULSE; j++) begin
            cnt_next_s[j] = cnt_r[j];
            if (wr_rise_s && is_pulse_s && (pulse_idx_s == PIW'(j))) begin
                cnt_next_s[j] = dataIn[0] ? PLEN : 8'h00;
            end else if (cnt_r[j] != 8'h00) begin
                cnt_next_s[j] = cnt_r[j] - 8'h01;
            end else begin
                cnt_next_s[j] = 8'h00;
            end
        end
    end

    // All registers: edge detectors, RAM port, page, config, snapshot, pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_d_r        <= 1'b0;
            rd_d_r        <= 1'b0;
            dataOut       <= 8'h00;
            ram_dataIn    <= 8'h00;
            ram_wraddress <= '0;
            ram_wren      <= 1'b0;
            page_r        <= '0;
            cfg_out       <= CFG_RESET;
            cfg_commit    <= 1'b0;
            snap_r        <= 32'h0000_0000;
            snap_idx_r    <= '0;
            snap_valid_r  <= 1'b0;
            pulse_out     <= '0;
            for (int i = 0; i < NUM_CFG; i++) begin
                staging_r[i] <= CFG_RESET[8*i +: 8];
            end
            for (int j = 0; j < NUM_PULSE; j++) begin
                cnt_r[j] <= 8'h00;
            end
        end else begin
            we_d_r     <= writeEn;
            rd_d_r     <= readEn;
            dataOut    <= rd_data_s;
            ram_dataIn <= dataIn;
            ram_wren   <= 1'b0;
            cfg_commit <= 1'b0;

            if (wr_rise_s) begin
                if (is_ram_s) begin
                    ram_wren      <= 1'b1;
                    ram_wraddress <= {page_r, addr[6:0]};
                end else if (is_page_s) begin
                    page_r <= dataIn[RAM_PAGE_BITS-1:0];
                end else if (is_cfg_s) begin
                    staging_r[cfg_idx_s] <= dataIn;
                end else if (is_commit_s) begin
                    for (int i = 0; i < NUM_CFG; i++) begin
                        cfg_out[8*i +: 8] <= staging_r[i];
                    end
                    cfg_commit <= 1'b1;
                end else begin
                    // Pulse writes are handled by the counter logic; other
                    // addresses are ignored.
                    page_r <= page_r;
                end
            end else begin
                page_r <= page_r;
            end

            // An MSB read captures the whole word from the same sample.
            if (rd_rise_s && is_stat_s && (stat_byte_s == 2'd0)) begin
                snap_r       <= live_word_s;
                snap_idx_r   <= stat_word_s;
                snap_valid_r <= 1'b1;
            end else begin
                snap_valid_r <= snap_valid_r;
            end

            for (int j = 0; j < NUM_PULSE; j++) begin
                cnt_r[j]     <= cnt_next_s[j];
                pulse_out[j] <= (cnt_next_s[j] != 8'h00);
            end
        end
    end

endmodule

// File: tb/tb_i2c_register_bank.sv
// ---------------------------------------------------------------------------
// tb_i2c_register_bank
//
// Directed self-checking bench for i2c_register_bank.  Config reg 2 resets to
// 8'h14 and the status region is moved to 8'hB0 so that it does not collide
// with the commit register at 8'hA0.  Inputs change on the falling edge and
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_i2c_register_bank;

    localparam logic [127:0] CFG_RST = 128'h0000_0000_0000_0000_0000_0000_0014_0000;

    logic         clk;
    logic         reset;
    logic [7:0]   addr;
    logic [7:0]   dataIn;
    logic         writeEn;
    logic         readEn;
    logic [7:0]   dataOut;
    logic [7:0]   ram_dataIn;
    logic [9:0]   ram_wraddress;
    logic         ram_wren;
    logic [127:0] cfg_out;
    logic         cfg_commit;
    logic [255:0] stat_in;
    logic [7:0]   pulse_out;

    int n_cmp  = 0;
    int n_fail = 0;

    i2c_register_bank #(
        .CFG_RESET (CFG_RST),
        .STAT_BASE (8'hB0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .addr          (addr),
        .dataIn        (dataIn),
        .writeEn       (writeEn),
        .readEn        (readEn),
        .dataOut       (dataOut),
        .ram_dataIn    (ram_dataIn),
        .ram_wraddress (ram_wraddress),
        .ram_wren      (ram_wren),
        .cfg_out       (cfg_out),
        .cfg_commit    (cfg_commit),
        .stat_in       (stat_in),
        .pulse_out     (pulse_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-byte write: acts on the next rising edge, returns one negedge later.
    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; dataIn = d; writeEn = 1'b1;
        @(negedge clk);
        writeEn = 1'b0;
    endtask

    // Single-byte read: dataOut sampled one cycle after addr is presented.
    task automatic do_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; readEn = 1'b1;
        @(negedge clk);
        d = dataOut;
        readEn = 1'b0;
    endtask

    // Start a pulse on channel 2, optionally retrigger or cancel at sample c,
    // and count how many sampled cycles pulse_out[2] was high.
    task automatic pulse_run(input int retrig_c, input int cancel_c, output int highs);
        highs = 0;
        @(negedge clk);
        addr = 8'hF2; dataIn = 8'h01; writeEn = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (pulse_out[2]) highs++;
            writeEn = 1'b0;
            if (c == retrig_c) begin
                dataIn = 8'h01; writeEn = 1'b1;
            end else if (c == cancel_c) begin
                dataIn = 8'h00; writeEn = 1'b1;
            end
        end
        writeEn = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b1; addr = 8'h00; dataIn = 8'h00; writeEn = 1'b0; readEn = 1'b0;
        stat_in = '0;
        stat_in[63:32] = 32'h00CD_0000;
        repeat (3) @(negedge clk);
        n_cmp++; if (cfg_out !== CFG_RST) begin n_fail++; $display("FAIL reset_cfg_out: got %h want %h", cfg_out, CFG_RST); end
        n_cmp++; if (cfg_out[23:16] !== 8'h14) begin n_fail++; $display("FAIL reset_cfg2: got %h want 14", cfg_out[23:16]); end
        n_cmp++; if (cfg_commit !== 1'b0) begin n_fail++; $display("FAIL reset_commit: got %b want 0", cfg_commit); end
        n_cmp++; if (pulse_out !== 8'h00) begin n_fail++; $display("FAIL reset_pulse: got %h want 00", pulse_out); end
        n_cmp++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL reset_dataOut: got %h want 00", dataOut); end
        n_cmp++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL reset_ram_wren: got %b want 0", ram_wren); end
        reset = 1'b0;
        do_read(8'hB5, d);
        n_cmp++; if (d !== 8'hCD) begin n_fail++; $display("FAIL live_offset_read: got %h want cd", d); end
    endtask

    task automatic test_osd();
        logic [7:0] d;
        int         wr_cnt;
        logic [9:0] wa;
        logic [7:0] wd;
        do_write(8'h80, 8'h03);
        do_read(8'h80, d);
        n_cmp++; if (d !== 8'h03) begin n_fail++; $display("FAIL page_read: got %h want 03", d); end
        wr_cnt = 0; wa = '0; wd = '0;
        @(negedge clk);
        addr = 8'h25; dataIn = 8'hAB; writeEn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ram_wren) begin
                wr_cnt++; wa = ram_wraddress; wd = ram_dataIn;
            end
            if (c == 4) writeEn = 1'b0;
        end
        n_cmp++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL osd_wren_count: got %0d want 1", wr_cnt); end
        n_cmp++; if (wa !== 10'h1A5) begin n_fail++; $display("FAIL osd_addr: got %h want 1a5", wa); end
        n_cmp++; if (wd !== 8'hAB) begin n_fail++; $display("FAIL osd_data: got %h want ab", wd); end
    endtask

    task automatic test_config();
        logic [7:0] d;
        do_write(8'h90, 8'h11);
        do_write(8'h91, 8'h22);
        n_cmp++; if (cfg_out !== CFG_RST) begin n_fail++; $display("FAIL cfg_before_commit: got %h want %h", cfg_out, CFG_RST); end
        do_read(8'h91, d);
        n_cmp++; if (d !== 8'h22) begin n_fail++; $display("FAIL staging_read: got %h want 22", d); end
        do_write(8'hA0, 8'h5A);
        n_cmp++; if (cfg_out[23:0] !== 24'h14_2211) begin n_fail++; $display("FAIL cfg_after_commit: got %h want 142211", cfg_out[23:0]); end
        n_cmp++; if (cfg_commit !== 1'b1) begin n_fail++; $display("FAIL commit_strobe: got %b want 1", cfg_commit); end
        @(negedge clk);
        n_cmp++; if (cfg_commit !== 1'b0) begin n_fail++; $display("FAIL commit_one_cycle: got %b want 0", cfg_commit); end
        do_read(8'hA0, d);
        n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL commit_read: got %h want 00", d); end
        do_read(8'h90, d);
        n_cmp++; if (d !== 8'h11) begin n_fail++; $display("FAIL staging_kept: got %h want 11", d); end
    endtask

    task automatic test_status();
        logic [7:0] d;
        logic [7:0] exp1 [4];
        logic [7:0] exp2 [4];
        exp1 = '{8'h00, 8'h00, 8'h00, 8'hFF};
        exp2 = '{8'h00, 8'h00, 8'h01, 8'h00};
        stat_in[63:32] = 32'h0000_00FF;
        do_read(8'hB4, d);
        n_cmp++; if (d !== exp1[0]) begin n_fail++; $display("FAIL snap_msb: got %h want %h", d, exp1[0]); end
        stat_in[63:32] = 32'h0000_0100;
        for (int b = 1; b < 4; b++) begin
            do_read(8'hB4 + 8'(b), d);
            n_cmp++; if (d !== exp1[b]) begin n_fail++; $display("FAIL snap_byte%0d: got %h want %h", b, d, exp1[b]); end
        end
        for (int b = 0; b < 4; b++) begin
            do_read(8'hB4 + 8'(b), d);
            n_cmp++; if (d !== exp2[b]) begin n_fail++; $display("FAIL fresh_byte%0d: got %h want %h", b, d, exp2[b]); end
        end
    endtask

    task automatic test_pulse();
        int highs;
        pulse_run(-1, -1, highs);
        n_cmp++; if (highs !== 4) begin n_fail++; $display("FAIL pulse_len: got %0d want 4", highs); end
        pulse_run(1, -1, highs);
        n_cmp++; if (highs !== 6) begin n_fail++; $display("FAIL pulse_retrigger: got %0d want 6", highs); end
        pulse_run(-1, 1, highs);
        n_cmp++; if (highs !== 2) begin n_fail++; $display("FAIL pulse_cancel: got %0d want 2", highs); end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] d;
        do_write(8'h90, 8'h55);
        do_read(8'hB4, d);
        stat_in[63:32] = 32'h0000_0200;
        do_write(8'hF3, 8'h01);
        n_cmp++; if (pulse_out[3] !== 1'b1) begin n_fail++; $display("FAIL pulse_pre_reset: got %b want 1", pulse_out[3]); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (pulse_out !== 8'h00) begin n_fail++; $display("FAIL reset_mid_pulse: got %h want 00", pulse_out); end
        n_cmp++; if (cfg_out !== CFG_RST) begin n_fail++; $display("FAIL reset_mid_cfg: got %h want %h", cfg_out, CFG_RST); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (pulse_out !== 8'h00) begin n_fail++; $display("FAIL pulse_after_reset: got %h want 00", pulse_out); end
        do_read(8'h90, d);
        n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL staging0_reset: got %h want 00", d); end
        do_read(8'h92, d);
        n_cmp++; if (d !== 8'h14) begin n_fail++; $display("FAIL staging2_reset: got %h want 14", d); end
        do_read(8'hB6, d);
        n_cmp++; if (d !== 8'h02) begin n_fail++; $display("FAIL snap_invalid: got %h want 02", d); end
    endtask

    initial begin
        test_reset();
        test_osd();
        test_config();
        test_status();
        test_pulse();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
